utlb_responder: RTL and testbench

Four-entry micro-TLB that services mapped-address lookups in the MIPS fetch/memory path and returns physical address, cacheability and TLB exception status. It sits behind the unmapped-segment converter: unmapped requests (need_tlb=0) pass straight through with the converter's physical address. Mapped requests are checked against the local entries. On a miss, the block acts as initiator toward the JTLB over a request/response handshake and refills one entry.

---
 rtl/utlb_responder.sv | 211 +++++++++++++++++++++
 tb/tb_utlb_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/utlb_responder.sv
// Four-entry micro-TLB with JTLB refill handshake; returns paddr, cacheability and TLB exceptions.
// Optional UTLB_STATS_EN adds saturating hit/miss counters.
module utlb_responder #(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned ASID_W  = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [31:0]       req_vaddr_i,
  input  logic              req_need_tlb_i,
  input  logic [31:0]       req_untlb_paddr_i,
  input  logic              req_untlb_cache_i,
  input  logic              req_store_i,
  input  logic [ASID_W-1:0] asid_i,
  input  logic              flush_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_paddr_o,
  output logic              resp_cache_o,
  output logic              resp_refill_o,
  output logic              resp_invalid_o,
  output logic              resp_modified_o,
  output logic              jtlb_req_valid_o,
  input  logic              jtlb_req_ready_i,
  output logic [19:0]       jtlb_vpn_o,
  output logic [ASID_W-1:0] jtlb_asid_o,
  input  logic              jtlb_resp_valid_i,
  input  logic              jtlb_hit_i,
  input  logic              jtlb_g_i,
  input  logic              jtlb_v_i,
  input  logic              jtlb_d_i,
  input  logic [19:0]       jtlb_pfn_i,
  input  logic [2:0]        jtlb_c_i
`ifdef UTLB_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int unsigned IdxW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e              state_q;
  logic [ENTRIES-1:0]  valid_q;
  logic [19:0]         vpn_q  [ENTRIES];
  logic [ASID_W-1:0]   asid_q [ENTRIES];
  logic                g_q    [ENTRIES];
  logic [19:0]         pfn_q  [ENTRIES];
  logic [2:0]          c_q    [ENTRIES];
  logic                d_q    [ENTRIES];
  logic [IdxW-1:0]     ptr_q;

  logic [19:0]         miss_vpn_q;
  logic [11:0]         miss_off_q;
  logic [ASID_W-1:0]   miss_asid_q;
  logic                miss_store_q;
  logic                flushed_q;

  logic                resp_valid_q, resp_cache_q, resp_refill_q, resp_invalid_q, resp_modified_q;
  logic [31:0]         resp_paddr_q;

  logic                hit_any, free_any, fill_en, hit_mod, wait_mod;
  logic [IdxW-1:0]     hit_idx, free_idx, fill_idx;

  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (valid_q[i] && vpn_q[i] == req_vaddr_i[31:12] && (g_q[i] || asid_q[i] == asid_i)) begin
        hit_any = 1'b1;
        hit_idx = IdxW'(i);
      end
    end
    // Descending scan so the lowest invalid index wins.
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IdxW'(i);
      end
    end
    fill_idx = free_any ? free_idx : ptr_q;
    hit_mod  = req_store_i & ~d_q[hit_idx];
    wait_mod = miss_store_q & ~jtlb_d_i;
    fill_en  = (state_q == StWait) && jtlb_resp_valid_i && jtlb_hit_i && jtlb_v_i &&
               !flush_i && !flushed_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= StIdle;
      valid_q         <= '0;
      ptr_q           <= '0;
      miss_vpn_q      <= '0;
      miss_off_q      <= '0;
      miss_asid_q     <= '0;
      miss_store_q    <= 1'b0;
      flushed_q       <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_paddr_q    <= '0;
      resp_cache_q    <= 1'b0;
      resp_refill_q   <= 1'b0;
      resp_invalid_q  <= 1'b0;
      resp_modified_q <= 1'b0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        vpn_q[i]  <= '0;
        asid_q[i] <= '0;
        g_q[i]    <= 1'b0;
        pfn_q[i]  <= '0;
        c_q[i]    <= '0;
        d_q[i]    <= 1'b0;
      end
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            if (!req_need_tlb_i) begin
              resp_valid_q    <= 1'b1;
              resp_paddr_q    <= req_untlb_paddr_i;
              resp_cache_q    <= req_untlb_cache_i;
              resp_refill_q   <= 1'b0;
              resp_invalid_q  <= 1'b0;
              resp_modified_q <= 1'b0;
            end else if (hit_any) begin
              resp_valid_q    <= 1'b1;
              resp_paddr_q    <= hit_mod ? 32'h0 : {pfn_q[hit_idx], req_vaddr_i[11:0]};
              resp_cache_q    <= ~hit_mod & (c_q[hit_idx] == 3'b011);
              resp_refill_q   <= 1'b0;
              resp_invalid_q  <= 1'b0;
              resp_modified_q <= hit_mod;
            end else begin
              miss_vpn_q   <= req_vaddr_i[31:12];
              miss_off_q   <= req_vaddr_i[11:0];
              miss_asid_q  <= asid_i;
              miss_store_q <= req_store_i;
              flushed_q    <= 1'b0;
              state_q      <= StReq;
            end
          end
        end
        StReq: begin
          if (jtlb_req_ready_i) state_q <= StWait;
        end
        StWait: begin
          if (jtlb_resp_valid_i) begin
            state_q         <= StIdle;
            resp_valid_q    <= 1'b1;
            resp_refill_q   <= ~jtlb_hit_i;
            resp_invalid_q  <= jtlb_hit_i & ~jtlb_v_i;
            resp_modified_q <= jtlb_hit_i & jtlb_v_i & wait_mod;
            if (jtlb_hit_i && jtlb_v_i && !wait_mod) begin
              resp_paddr_q <= {jtlb_pfn_i, miss_off_q};
              resp_cache_q <= (jtlb_c_i == 3'b011);
            end else begin
              resp_paddr_q <= '0;
              resp_cache_q <= 1'b0;
            end
            if (fill_en) begin
              valid_q[fill_idx] <= 1'b1;
              vpn_q[fill_idx]   <= miss_vpn_q;
              asid_q[fill_idx]  <= miss_asid_q;
              g_q[fill_idx]     <= jtlb_g_i;
              pfn_q[fill_idx]   <= jtlb_pfn_i;
              c_q[fill_idx]     <= jtlb_c_i;
              d_q[fill_idx]     <= jtlb_d_i;
              if (!free_any) ptr_q <= (ptr_q == IdxW'(ENTRIES - 1)) ? '0 : ptr_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
      // A flush anywhere during a miss suppresses the later install.
      if (flush_i) begin
        valid_q   <= '0;
        flushed_q <= 1'b1;
      end
    end
  end

`ifdef UTLB_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == StIdle && req_valid_i && req_need_tlb_i) begin
      if (hit_any && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 1'b1;
      if (!hit_any && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end
  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

  assign req_ready_o      = resetn && (state_q == StIdle);
  assign jtlb_req_valid_o = (state_q == StReq);
  assign jtlb_vpn_o       = miss_vpn_q;
  assign jtlb_asid_o      = miss_asid_q;
  assign resp_valid_o     = resp_valid_q;
  assign resp_paddr_o     = resp_paddr_q;
  assign resp_cache_o     = resp_cache_q;
  assign resp_refill_o    = resp_refill_q;
  assign resp_invalid_o   = resp_invalid_q;
  assign resp_modified_o  = resp_modified_q;

endmodule

// File: tb/tb_utlb_responder.sv
// Directed table-driven bench for utlb_responder: lookups, refills, exceptions, replacement, flush.
module tb_utlb_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid_i, req_ready_o, req_need_tlb_i, req_untlb_cache_i, req_store_i;
  logic [31:0] req_vaddr_i, req_untlb_paddr_i;
  logic [7:0]  asid_i;
  logic        flush_i;
  logic        resp_valid_o, resp_cache_o, resp_refill_o, resp_invalid_o, resp_modified_o;
  logic [31:0] resp_paddr_o;
  logic        jtlb_req_valid_o, jtlb_req_ready_i;
  logic [19:0] jtlb_vpn_o;
  logic [7:0]  jtlb_asid_o;
  logic        jtlb_resp_valid_i, jtlb_hit_i, jtlb_g_i, jtlb_v_i, jtlb_d_i;
  logic [19:0] jtlb_pfn_i;
  logic [2:0]  jtlb_c_i;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  utlb_responder #(.ENTRIES(4), .ASID_W(8)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_vaddr_i       (req_vaddr_i),
    .req_need_tlb_i    (req_need_tlb_i),
    .req_untlb_paddr_i (req_untlb_paddr_i),
    .req_untlb_cache_i (req_untlb_cache_i),
    .req_store_i       (req_store_i),
    .asid_i            (asid_i),
    .flush_i           (flush_i),
    .resp_valid_o      (resp_valid_o),
    .resp_paddr_o      (resp_paddr_o),
    .resp_cache_o      (resp_cache_o),
    .resp_refill_o     (resp_refill_o),
    .resp_invalid_o    (resp_invalid_o),
    .resp_modified_o   (resp_modified_o),
    .jtlb_req_valid_o  (jtlb_req_valid_o),
    .jtlb_req_ready_i  (jtlb_req_ready_i),
    .jtlb_vpn_o        (jtlb_vpn_o),
    .jtlb_asid_o       (jtlb_asid_o),
    .jtlb_resp_valid_i (jtlb_resp_valid_i),
    .jtlb_hit_i        (jtlb_hit_i),
    .jtlb_g_i          (jtlb_g_i),
    .jtlb_v_i          (jtlb_v_i),
    .jtlb_d_i          (jtlb_d_i),
    .jtlb_pfn_i        (jtlb_pfn_i),
    .jtlb_c_i          (jtlb_c_i)
  );

  typedef struct {
    logic        need;
    logic [31:0] vaddr;
    logic [31:0] upaddr;
    logic        ucache;
    logic        store;
    logic [7:0]  asid;
    logic        flush_wait;
    logic        jhit, jg, jv, jd;
    logic [19:0] jpfn;
    logic [2:0]  jc;
    logic        exp_miss;
    logic [31:0] exp_paddr;
    logic        exp_cache, exp_ref, exp_inv, exp_mod;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic miss_seen;
    @(negedge clk);
    chk($sformatf("v%0d_ready", idx), {31'b0, req_ready_o}, 32'd1);
    req_valid_i       = 1'b1;
    req_need_tlb_i    = v.need;
    req_vaddr_i       = v.vaddr;
    req_untlb_paddr_i = v.upaddr;
    req_untlb_cache_i = v.ucache;
    req_store_i       = v.store;
    asid_i            = v.asid;
    @(negedge clk);
    req_valid_i = 1'b0;
    miss_seen   = jtlb_req_valid_o;
    chk($sformatf("v%0d_jtlb_req", idx), {31'b0, miss_seen}, {31'b0, v.exp_miss});
    if (miss_seen) begin
      chk($sformatf("v%0d_vpn", idx), {12'b0, jtlb_vpn_o}, {12'b0, v.vaddr[31:12]});
      chk($sformatf("v%0d_asid", idx), {24'b0, jtlb_asid_o}, {24'b0, v.asid});
      @(negedge clk);
      chk($sformatf("v%0d_req_hold", idx), {31'b0, jtlb_req_valid_o}, 32'd1);
      jtlb_req_ready_i = 1'b1;
      @(negedge clk);
      jtlb_req_ready_i = 1'b0;
      if (v.flush_wait) begin
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
      end
      jtlb_resp_valid_i = 1'b1;
      jtlb_hit_i = v.jhit;
      jtlb_g_i   = v.jg;
      jtlb_v_i   = v.jv;
      jtlb_d_i   = v.jd;
      jtlb_pfn_i = v.jpfn;
      jtlb_c_i   = v.jc;
      @(negedge clk);
      jtlb_resp_valid_i = 1'b0;
    end
    chk($sformatf("v%0d_resp_valid", idx), {31'b0, resp_valid_o}, 32'd1);
    chk($sformatf("v%0d_paddr", idx), resp_paddr_o, v.exp_paddr);
    chk($sformatf("v%0d_flags", idx),
        {28'b0, resp_cache_o, resp_refill_o, resp_invalid_o, resp_modified_o},
        {28'b0, v.exp_cache, v.exp_ref, v.exp_inv, v.exp_mod});
    chk($sformatf("v%0d_ready_after", idx), {31'b0, req_ready_o}, 32'd1);
  endtask

  initial begin
    vec_t tmp;
    resetn = 1'b0;
    req_valid_i = 0; req_need_tlb_i = 0; req_vaddr_i = 0; req_untlb_paddr_i = 0;
    req_untlb_cache_i = 0; req_store_i = 0; asid_i = 0; flush_i = 0;
    jtlb_req_ready_i = 0; jtlb_resp_valid_i = 0; jtlb_hit_i = 0; jtlb_g_i = 0;
    jtlb_v_i = 0; jtlb_d_i = 0; jtlb_pfn_i = 0; jtlb_c_i = 0;

    // need vaddr upaddr uc st asid fw | jhit jg jv jd jpfn jc | miss paddr cache ref inv mod
    vecs[0]  = '{0, 32'hBFC0_0000, 32'h1FC0_0000, 0, 0, 5, 0, 0, 0, 0, 0, 20'h0, 3'd0,
                 0, 32'h1FC0_0000, 0, 0, 0, 0};
    vecs[1]  = '{1, 32'h0040_1234, 0, 0, 0, 5, 0, 1, 0, 1, 1, 20'h12345, 3'd3,
                 1, 32'h1234_5234, 1, 0, 0, 0};
    vecs[2]  = '{1, 32'h0040_1234, 0, 0, 0, 5, 0, 0, 0, 0, 0, 20'h0, 3'd0,
                 0, 32'h1234_5234, 1, 0, 0, 0};
    vecs[3]  = '{1, 32'h0040_1234, 0, 0, 0, 6, 0, 0, 0, 0, 0, 20'h0, 3'd0,
                 1, 32'h0, 0, 1, 0, 0};
    vecs[4]  = '{1, 32'h0050_0010, 0, 0, 0, 5, 0, 1, 0, 0, 1, 20'h00050, 3'd3,
                 1, 32'h0, 0, 0, 1, 0};
    vecs[5]  = '{1, 32'h0060_0ABC, 0, 0, 1, 5, 0, 1, 1, 1, 0, 20'h00AAA, 3'd3,
                 1, 32'h0, 0, 0, 0, 1};
    vecs[6]  = '{1, 32'h0060_0004, 0, 0, 0, 6, 0, 0, 0, 0, 0, 20'h0, 3'd0,
                 0, 32'h00AA_A004, 1, 0, 0, 0};
    vecs[7]  = '{1, 32'h0060_0008, 0, 0, 1, 6, 0, 0, 0, 0, 0, 20'h0, 3'd0,
                 0, 32'h0, 0, 0, 0, 1};
    vecs[8]  = '{1, 32'h0070_0000, 0, 0, 0, 5, 0, 1, 0, 1, 1, 20'h00070, 3'd2,
                 1, 32'h0007_0000, 0, 0, 0, 0};
    vecs[9]  = '{1, 32'h0080_0100, 0, 0, 0, 5, 0, 1, 0, 1, 1, 20'h00080, 3'd3,
                 1, 32'h0008_0100, 1, 0, 0, 0};
    vecs[10] = '{1, 32'h0090_0200, 0, 0, 0, 5, 0, 1, 0, 1, 1, 20'h00090, 3'd3,
                 1, 32'h0009_0200, 1, 0, 0, 0};
    vecs[11] = '{1, 32'h0040_1234, 0, 0, 0, 5, 0, 1, 0, 1, 1, 20'h12345, 3'd3,
                 1, 32'h1234_5234, 1, 0, 0, 0};
    vecs[12] = '{1, 32'h0060_0000, 0, 0, 0, 5, 0, 0, 0, 0, 0, 20'h0, 3'd0,
                 1, 32'h0, 0, 1, 0, 0};
    vecs[13] = '{1, 32'h0090_0200, 0, 0, 0, 5, 0, 0, 0, 0, 0, 20'h0, 3'd0,
                 0, 32'h0009_0200, 1, 0, 0, 0};
    vecs[14] = '{1, 32'h0070_0004, 0, 0, 0, 5, 0, 0, 0, 0, 0, 20'h0, 3'd0,
                 0, 32'h0007_0004, 0, 0, 0, 0};
    vecs[15] = '{1, 32'h00A0_0000, 0, 0, 0, 5, 1, 1, 0, 1, 1, 20'h000A0, 3'd3,
                 1, 32'h000A_0000, 1, 0, 0, 0};
    vecs[16] = '{1, 32'h0090_0200, 0, 0, 0, 5, 0, 0, 0, 0, 0, 20'h0, 3'd0,
                 1, 32'h0, 0, 1, 0, 0};
    vecs[17] = '{1, 32'h00A0_0000, 0, 0, 0, 5, 0, 0, 0, 0, 0, 20'h0, 3'd0,
                 1, 32'h0, 0, 1, 0, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready_o}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid_o}, 32'd0);
    chk("rst_jtlb_req", {31'b0, jtlb_req_valid_o}, 32'd0);
    chk("rst_paddr", resp_paddr_o, 32'd0);
    chk("rst_flags", {28'b0, resp_cache_o, resp_refill_o, resp_invalid_o, resp_modified_o},
        32'd0);
    resetn = 1'b1;
    #1;
    chk("rst_release_ready", {31'b0, req_ready_o}, 32'd1);

    for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

    // Fill one page, then two back-to-back hits at one lookup per cycle.
    tmp = '{1, 32'h00B0_0123, 0, 0, 0, 5, 0, 1, 0, 1, 1, 20'h000B0, 3'd3,
            1, 32'h000B_0123, 1, 0, 0, 0};
    run_vec(18, tmp);
    @(negedge clk);
    req_valid_i = 1'b1; req_need_tlb_i = 1'b1; req_store_i = 1'b0; asid_i = 8'd5;
    req_vaddr_i = 32'h00B0_0001;
    @(negedge clk);
    chk("b2b_0_valid", {31'b0, resp_valid_o}, 32'd1);
    chk("b2b_0_paddr", resp_paddr_o, 32'h000B_0001);
    chk("b2b_ready", {31'b0, req_ready_o}, 32'd1);
    req_vaddr_i = 32'h00B0_0002;
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("b2b_1_valid", {31'b0, resp_valid_o}, 32'd1);
    chk("b2b_1_paddr", resp_paddr_o, 32'h000B_0002);
    chk("b2b_no_jtlb", {31'b0, jtlb_req_valid_o}, 32'd0);
    @(negedge clk);
    chk("resp_pulse", {31'b0, resp_valid_o}, 32'd0);
    chk("resp_hold_paddr", resp_paddr_o, 32'h000B_0002);

    // Reset in the middle of a miss: abandoned, no response, entries cleared.
    req_valid_i = 1'b1; req_vaddr_i = 32'h00C0_0000;
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("mid_miss_req", {31'b0, jtlb_req_valid_o}, 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_jtlb_req", {31'b0, jtlb_req_valid_o}, 32'd0);
    chk("mid_rst_resp", {31'b0, resp_valid_o}, 32'd0);
    chk("mid_rst_ready", {31'b0, req_ready_o}, 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_no_resp", {31'b0, resp_valid_o}, 32'd0);
    tmp = '{1, 32'h00B0_0001, 0, 0, 0, 5, 0, 0, 0, 0, 0, 20'h0, 3'd0,
            1, 32'h0, 0, 1, 0, 0};
    run_vec(19, tmp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
